// File: rtl/serial_pkg.sv
// Shared types and line levels for the single-bit serial transmitter and its matching receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } serial_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count with Tick.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    output logic Tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrapping on Tick restarts the count at every bit boundary, which is
    // also every state entry, so each bit lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (Clear || Tick) begin
            cnt_d = '0;
        end
    end

    assign Tick = (cnt_q == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_bit_tx.sv
// Framed LSB-first serial transmitter: start bit, DATA_W payload bits, stop bit, valid/ready input.
module serial_bit_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data,
    input  logic              Start,
    output logic              Ready,
    output logic              Tx,
    output logic              Busy,
    output logic              Done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    serial_state_e     state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              timer_clear;

    // Holding the timer cleared while idle makes the start bit begin at count 0.
    assign timer_clear = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .Clear (timer_clear),
        .Tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d   = START;
                    shift_d   = Data;
                    bit_idx_d = '0;
                    tx_d      = START_BIT;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= IDLE_LEVEL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Tx    = tx_q;
    assign Ready = ready_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule
